instr_fetch: RTL and testbench



---
 rtl/proc_pkg.sv | 36 +++
 rtl/instr_fetch_if.sv | 38 +++
 rtl/instr_fetch_pc_reg.sv | 43 ++++
 rtl/instr_fetch.sv | 93 +++++++++
 tb/tb_instr_fetch.sv | 226 ++++++++++++++++++++++
 5 files changed

// File: rtl/proc_pkg.sv
// ============================================================================
// Module   : proc_pkg
// Brief    : Shared opcodes, fetch state encoding and width defaults.
// Revision : 1.0
// ============================================================================
`default_nettype none

package proc_pkg;

  localparam int ADDR_W = 5;
  localparam int DATA_W = 16;
  localparam int IR_W   = 9;

  localparam logic [2:0] OP_MV  = 3'b000;
  localparam logic [2:0] OP_MVI = 3'b001;
  localparam logic [2:0] OP_ADD = 3'b010;
  localparam logic [2:0] OP_SUB = 3'b011;
  localparam logic [2:0] OP_OR  = 3'b100;
  localparam logic [2:0] OP_SLT = 3'b101;
  localparam logic [2:0] OP_SLL = 3'b110;
  localparam logic [2:0] OP_SRL = 3'b111;

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_FETCH = 2'd1,
    S_IMM   = 2'd2,
    S_ISSUE = 2'd3
  } fetch_state_e;

  function automatic logic is_mvi_op(input logic [2:0] op);
    return op == OP_MVI;
  endfunction

endpackage

`default_nettype wire

// File: rtl/instr_fetch_if.sv
// ============================================================================
// Module   : instr_fetch_if
// Brief    : Memory port, control inputs and issue handshake of the fetcher.
// Revision : 1.0
// ============================================================================
`default_nettype none

interface instr_fetch_if #(
  parameter int ADDR_W = proc_pkg::ADDR_W,
  parameter int DATA_W = proc_pkg::DATA_W,
  parameter int IR_W   = proc_pkg::IR_W
) ();

  logic              Run;
  logic              pc_load;
  logic [ADDR_W-1:0] pc_in;
  logic [ADDR_W-1:0] mem_addr;
  logic [DATA_W-1:0] mem_data;
  logic [IR_W-1:0]   IR;
  logic [DATA_W-1:0] Imm;
  logic              is_mvi;
  logic              instr_valid;
  logic              instr_ready;
  logic [ADDR_W-1:0] PC;

  modport master (
    input  Run, pc_load, pc_in, mem_data, instr_ready,
    output mem_addr, IR, Imm, is_mvi, instr_valid, PC
  );

  modport slave (
    output Run, pc_load, pc_in, mem_data, instr_ready,
    input  mem_addr, IR, Imm, is_mvi, instr_valid, PC
  );

endinterface

`default_nettype wire

// File: rtl/instr_fetch_pc_reg.sv
// ============================================================================
// Module   : pc_reg
// Brief    : Program counter with load, increment and hold; wraps modulo 2^W.
// Revision : 1.0
// ============================================================================
`default_nettype none

module pc_reg #(
  parameter int ADDR_W = 5
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              inc_i,
  input  logic              load_i,
  input  logic [ADDR_W-1:0] load_val_i,
  output logic [ADDR_W-1:0] pc_o
);

  logic [ADDR_W-1:0] pc_q;
  logic [ADDR_W-1:0] pc_d;

  always_comb begin
    pc_d = pc_q;
    if (load_i) begin
      pc_d = load_val_i;
    end else if (inc_i) begin
      pc_d = pc_q + ADDR_W'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      pc_q <= '0;
    end else begin
      pc_q <= pc_d;
    end
  end

  assign pc_o = pc_q;

endmodule

`default_nettype wire

// File: rtl/instr_fetch.sv
// ============================================================================
// Module   : instr_fetch
// Brief    : Fetch sequencer: reads instruction (+ MVI immediate), issues it.
// Revision : 1.0
// ============================================================================
`default_nettype none

module instr_fetch
  import proc_pkg::*;
#(
  parameter int ADDR_W = proc_pkg::ADDR_W,
  parameter int DATA_W = proc_pkg::DATA_W,
  parameter int IR_W   = proc_pkg::IR_W
) (
  input  logic          Clock,
  input  logic          Resetn,
  instr_fetch_if.master bus
);

  fetch_state_e      state_q, state_d;
  logic [IR_W-1:0]   ir_q, ir_d;
  logic [DATA_W-1:0] imm_q, imm_d;
  logic              pc_inc;
  logic              pc_ld;
  logic [ADDR_W-1:0] pc;

  pc_reg #(
    .ADDR_W (ADDR_W)
  ) u_pc_reg (
    .clk        (Clock),
    .rst        (Resetn),
    .inc_i      (pc_inc),
    .load_i     (pc_ld),
    .load_val_i (bus.pc_in),
    .pc_o       (pc)
  );

  always_comb begin
    state_d = state_q;
    ir_d    = ir_q;
    imm_d   = imm_q;
    pc_inc  = 1'b0;
    pc_ld   = 1'b0;
    case (state_q)
      S_IDLE: begin
        pc_ld = bus.pc_load;
        if (bus.Run) begin
          state_d = S_FETCH;
        end
      end
      S_FETCH: begin
        ir_d    = bus.mem_data[IR_W-1:0];
        pc_inc  = 1'b1;
        state_d = is_mvi_op(bus.mem_data[IR_W-1 -: 3]) ? S_IMM : S_ISSUE;
      end
      S_IMM: begin
        imm_d   = bus.mem_data;
        pc_inc  = 1'b1;
        state_d = S_ISSUE;
      end
      S_ISSUE: begin
        // Everything is held until downstream takes the instruction.
        if (bus.instr_ready) begin
          pc_ld   = bus.pc_load;
          state_d = bus.Run ? S_FETCH : S_IDLE;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge Clock) begin
    if (Resetn) begin
      state_q <= S_IDLE;
      ir_q    <= '0;
      imm_q   <= '0;
    end else begin
      state_q <= state_d;
      ir_q    <= ir_d;
      imm_q   <= imm_d;
    end
  end

  assign bus.mem_addr    = pc;
  assign bus.PC          = pc;
  assign bus.IR          = ir_q;
  assign bus.Imm         = imm_q;
  assign bus.is_mvi      = is_mvi_op(ir_q[IR_W-1 -: 3]);
  assign bus.instr_valid = (state_q == S_ISSUE);

endmodule

`default_nettype wire

// File: tb/tb_instr_fetch.sv
// ============================================================================
// Module   : tb_instr_fetch
// Brief    : Scoreboard bench for instr_fetch against a behavioural memory.
// Revision : 1.0
// ============================================================================
`default_nettype none

module tb_instr_fetch;

  logic Clock = 1'b0;
  logic Resetn;

  instr_fetch_if bus ();

  instr_fetch u_dut (
    .Clock  (Clock),
    .Resetn (Resetn),
    .bus    (bus)
  );

  always #5 Clock = ~Clock;

  logic [15:0] mem [32];
  assign bus.mem_data = mem[bus.mem_addr];

  typedef struct packed {
    logic [8:0]  ir;
    logic [15:0] imm;
    logic        mvi;
    logic [4:0]  pc;
  } exp_t;

  exp_t        sb [$];
  logic [15:0] model_imm;
  int          n_run  = 0;
  int          n_fail = 0;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_run++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge Clock);
    #1;
  endtask

  // Walk one instruction from the current memory image starting at start.
  task automatic predict(input logic [4:0] start, output logic [4:0] nxt);
    exp_t       e;
    logic [4:0] p = start;
    e.ir  = mem[p][8:0];
    e.mvi = (mem[p][8:6] == 3'b001);
    p     = p + 5'd1;
    if (e.mvi) begin
      model_imm = mem[p];
      p         = p + 5'd1;
    end
    e.imm = model_imm;
    e.pc  = p;
    sb.push_back(e);
    nxt = p;
  endtask

  task automatic wait_valid(input int max_cyc);
    int k = 0;
    while (!bus.instr_valid && k < max_cyc) begin
      tick();
      k++;
    end
    if (!bus.instr_valid) chk("valid_timeout", 32'd0, 32'd1);
  endtask

  always @(negedge Clock) begin
    if (!Resetn && bus.instr_valid && bus.instr_ready) begin
      if (sb.size() == 0) begin
        chk("sb_underflow", 32'd1, 32'd0);
      end else begin
        exp_t e;
        e = sb.pop_front();
        chk("hs_ir",  32'(bus.IR),     32'(e.ir));
        chk("hs_imm", 32'(bus.Imm),    32'(e.imm));
        chk("hs_mvi", 32'(bus.is_mvi), 32'(e.mvi));
        chk("hs_pc",  32'(bus.PC),     32'(e.pc));
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [4:0] np;
    for (int i = 0; i < 32; i++) mem[i] = 16'h0000;
    mem[0] = 16'h0040; mem[1] = 16'h0002; mem[2] = 16'h0048;
    mem[3] = 16'h0003; mem[4] = 16'h0088;
    model_imm       = 16'h0000;
    Resetn          = 1'b1;
    bus.Run         = 1'b1;
    bus.pc_load     = 1'b0;
    bus.pc_in       = 5'd0;
    bus.instr_ready = 1'b1;
    repeat (3) tick();
    chk("rst_valid", 32'(bus.instr_valid), 32'd0);
    chk("rst_pc",    32'(bus.PC),          32'd0);
    chk("rst_ir",    32'(bus.IR),          32'd0);
    chk("rst_imm",   32'(bus.Imm),         32'd0);
    chk("rst_mvi",   32'(bus.is_mvi),      32'd0);

    // Standard program, handshakes pulsed one at a time.
    predict(5'd0, np); predict(np, np); predict(np, np);
    bus.instr_ready = 1'b0;
    Resetn = 1'b0;
    tick();
    chk("c1_fetch_addr",  32'(bus.mem_addr),    32'd0);
    chk("c1_valid",       32'(bus.instr_valid), 32'd0);
    tick();
    chk("c2_imm_addr",    32'(bus.mem_addr),    32'd1);
    chk("c2_valid",       32'(bus.instr_valid), 32'd0);
    for (int n = 0; n < 2; n++) begin
      wait_valid(8);
      bus.instr_ready = 1'b1;
      tick();
      bus.instr_ready = 1'b0;
    end

    // ADD held under back-pressure.
    wait_valid(8);
    for (int n = 0; n < 5; n++) begin
      tick();
      chk("hold_valid", 32'(bus.instr_valid), 32'd1);
      chk("hold_ir",    32'(bus.IR),          32'h088);
      chk("hold_pc",    32'(bus.PC),          32'd5);
    end
    predict(5'd5, np);
    bus.instr_ready = 1'b1;
    tick();
    chk("rel_valid", 32'(bus.instr_valid), 32'd0);
    chk("rel_addr",  32'(bus.mem_addr),    32'd5);
    bus.Run = 1'b0;
    repeat (3) tick();
    chk("idle_valid", 32'(bus.instr_valid), 32'd0);
    chk("idle_addr",  32'(bus.mem_addr),    32'd6);

    // MVI at 31 wraps to 0 for its immediate; Run dropped during IMM.
    mem[31] = 16'h0050;
    mem[0]  = 16'h1234;
    bus.pc_load = 1'b1;
    bus.pc_in   = 5'd31;
    tick();
    bus.pc_load = 1'b0;
    chk("load31_addr", 32'(bus.mem_addr), 32'd31);
    predict(5'd31, np);
    bus.Run = 1'b1;
    tick();
    chk("wrap_fetch_addr", 32'(bus.mem_addr), 32'd31);
    tick();
    chk("wrap_imm_addr", 32'(bus.mem_addr), 32'd0);
    bus.Run = 1'b0;
    tick();
    chk("wrap_issue_valid", 32'(bus.instr_valid), 32'd1);
    chk("wrap_issue_imm",   32'(bus.Imm),         32'h1234);
    chk("wrap_issue_pc",    32'(bus.PC),          32'd1);
    tick();
    chk("drop_valid", 32'(bus.instr_valid), 32'd0);
    tick();
    chk("drop_idle_valid", 32'(bus.instr_valid), 32'd0);
    chk("drop_idle_addr",  32'(bus.mem_addr),    32'd1);

    // Jump on the handshake; pc_load during FETCH is ignored.
    mem[20] = 16'h00D1;
    predict(5'd1, np);
    predict(5'd20, np);
    bus.Run         = 1'b1;
    bus.instr_ready = 1'b0;
    wait_valid(8);
    chk("jmp_src_ir", 32'(bus.IR), 32'h002);
    bus.instr_ready = 1'b1;
    bus.pc_load     = 1'b1;
    bus.pc_in       = 5'd20;
    tick();
    chk("jmp_fetch_addr", 32'(bus.mem_addr), 32'd20);
    bus.pc_in = 5'd7;
    bus.Run   = 1'b0;
    tick();
    bus.pc_load = 1'b0;
    chk("ign_load_pc",    32'(bus.PC),          32'd21);
    chk("ign_load_valid", 32'(bus.instr_valid), 32'd1);
    tick();
    chk("jmp_done_valid", 32'(bus.instr_valid), 32'd0);
    chk("jmp_done_pc",    32'(bus.PC),          32'd21);

    // Reset while an instruction is offered without ready.
    mem[21] = 16'h0088;
    bus.Run         = 1'b1;
    bus.instr_ready = 1'b0;
    wait_valid(8);
    chk("pre_rst_ir", 32'(bus.IR), 32'h088);
    Resetn = 1'b1;
    tick();
    chk("mid_rst_valid", 32'(bus.instr_valid), 32'd0);
    chk("mid_rst_pc",    32'(bus.PC),          32'd0);
    chk("mid_rst_ir",    32'(bus.IR),          32'd0);
    chk("mid_rst_imm",   32'(bus.Imm),         32'd0);
    chk("mid_rst_mvi",   32'(bus.is_mvi),      32'd0);
    Resetn  = 1'b0;
    bus.Run = 1'b0;
    tick();
    tick();
    chk("post_rst_idle_valid", 32'(bus.instr_valid), 32'd0);
    chk("post_rst_idle_addr",  32'(bus.mem_addr),    32'd0);

    chk("sb_drain", 32'(sb.size()), 32'd0);
    $display("[TB] %0d tests run, %0d failed", n_run, n_fail);
    $finish;
  end

endmodule

`default_nettype wire
